// File: rtl/uart_ip_rx_core.sv
// UART receive front end: 2-flop rx synchroniser, oversampled deframer (8 data bits,
// optional parity, 1 or 2 stop bits) and sticky status flags for the control FSM.
module uart_ip_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] cfg_baud_div,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
  input  logic                 clr,
  output logic [7:0]           recv_data,
  output logic                 recv_int,
  output logic                 recv_busy,
  output logic                 recv_error,
  output logic [2:0]           dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 seen_high_q, seen_high_d;
  logic                 done_q, done_d;
  logic [7:0]           data_q, data_d;
  logic                 int_q, int_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 tick, samp, bend;

  always_comb begin
    tick = (state_q != IDLE) && (div_q == cfg_baud_div);
    samp = tick && (tick_q == TW'(OVERSAMPLE/2 - 1));
    bend = tick && (tick_q == TW'(OVERSAMPLE - 1));
  end

  // Counters idle at zero so every frame starts from a clean bit phase.
  always_comb begin
    div_d       = (state_q == IDLE || tick) ? '0 : div_q + DIV_WIDTH'(1);
    tick_d      = (state_q == IDLE) ? '0 : (tick ? tick_q + TW'(1) : tick_q);
    // A break must release the line before another start bit is accepted.
    seen_high_d = (state_q == IDLE) ? (seen_high_q | rx_s_q) : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q && seen_high_q) begin
          state_d   = START;
          bit_d     = 4'd0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      START: begin
        if (samp && rx_s_q) state_d = IDLE;
        else if (bend)      state_d = DATA;
      end
      DATA: begin
        if (samp) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
        end
        if (bend && bit_q == 4'd8) state_d = cfg_parity_en ? PARITY : STOP;
      end
      PARITY: begin
        if (samp && (((^shift_q) ^ rx_s_q) != cfg_parity_odd)) par_err_d = 1'b1;
        if (bend) state_d = STOP;
      end
      STOP: begin
        if (samp) begin
          if (!rx_s_q) frm_err_d = 1'b1;
          // Single stop bit completes mid-bit so a following start edge is not missed.
          if (!cfg_two_stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        if (bend) state_d = STOP2;
      end
      STOP2: begin
        if (samp) begin
          if (!rx_s_q) frm_err_d = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion outranks a coincident clr, and the cleared flag is not an overrun.
  always_comb begin
    data_d = done_q ? shift_q : data_q;
    int_d  = done_q ? 1'b1 : (clr ? 1'b0 : int_q);
    err_d  = done_q ? (par_err_q | frm_err_q | ((int_q | err_q) & !clr))
                    : (clr ? 1'b0 : err_q);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      div_q       <= '0;
      tick_q      <= '0;
      bit_q       <= 4'd0;
      shift_q     <= 8'h00;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      seen_high_q <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= 8'h00;
      int_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      seen_high_q <= seen_high_d;
      done_q      <= done_d;
      data_q      <= data_d;
      int_q       <= int_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign recv_data  = data_q;
  assign recv_int   = int_q;
  assign recv_busy  = busy_q;
  assign recv_error = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_ip_rx_core.sv
// Directed plus randomized bench for uart_ip_rx_core with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_ip_rx_core;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        rx;
  logic [15:0] cfg_baud_div;
  logic        cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic        clr;
  logic [7:0]  recv_data;
  logic        recv_int, recv_busy, recv_error;
  logic [2:0]  dbg_state;

  uart_ip_rx_core #(.OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
    .clk(clk), .arst_n(arst_n), .rx(rx), .cfg_baud_div(cfg_baud_div),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop(cfg_two_stop), .clr(clr), .recv_data(recv_data),
    .recv_int(recv_int), .recv_busy(recv_busy), .recv_error(recv_error),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last byte and sticky flags as seen by software.
  logic [7:0] m_data;
  logic       m_int, m_err;

  int  busy_cnt;
  bit  found;
  bit  seen_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_clks();
    return OS * (int'(cfg_baud_div) + 1);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(bit_clks());
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop1, input logic stop2);
    logic pe, fe;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (cfg_parity_en) send_bit((^d) ^ cfg_parity_odd ^ par_flip);
    send_bit(stop1);
    if (cfg_two_stop) send_bit(stop2);
    pe = cfg_parity_en & par_flip;
    fe = !stop1 | (cfg_two_stop & !stop2);
    m_err  = m_err | pe | fe | m_int;
    m_int  = 1'b1;
    m_data = d;
  endtask

  task automatic check_flags(input string tag);
    @(negedge clk);
    check({tag, "_data"}, 32'(recv_data), 32'(m_data));
    check({tag, "_int"},  32'(recv_int),  32'(m_int));
    check({tag, "_err"},  32'(recv_error), 32'(m_err));
    @(posedge clk);
    #1;
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] d, input logic par_flip,
                                 input logic stop1, input logic stop2);
    send_frame(d, par_flip, stop1, stop2);
    rx = 1'b1;
    wait_clks(bit_clks());
    check_flags(tag);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
    m_int = 1'b0;
    m_err = 1'b0;
    check_flags(tag);
  endtask

  task automatic set_cfg(input logic pen, input logic podd, input logic two);
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_two_stop   = two;
  endtask

  initial begin
    arst_n = 1'b0; rx = 1'b1; clr = 1'b0; cfg_baud_div = 16'd3;
    set_cfg(1'b0, 1'b0, 1'b0);
    m_data = 8'h00; m_int = 1'b0; m_err = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("rst_busy", 32'(recv_busy), 32'd0);
    @(posedge clk); #1;
    check_flags("rst");
    arst_n = 1'b1;
    wait_clks(4);

    // 8N1 0xA5 with busy length measurement
    busy_cnt = 0;
    fork
      begin
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        rx = 1'b1;
      end
      begin
        repeat (700) begin
          @(negedge clk);
          if (recv_busy) busy_cnt++;
        end
      end
    join
    @(posedge clk); #1;
    check("busy_len_in_600_616", 32'(busy_cnt >= 600 && busy_cnt <= 616), 32'd1);
    check_flags("a5_8n1");

    // 8E1 parity good then bad
    do_clr("clr1");
    set_cfg(1'b1, 1'b0, 1'b0);
    frame_and_check("p_good", 8'h03, 1'b0, 1'b1, 1'b1);
    do_clr("clr2");
    frame_and_check("p_bad", 8'h03, 1'b1, 1'b1, 1'b1);

    // 8N2 with bad second stop bit
    do_clr("clr3");
    set_cfg(1'b0, 1'b0, 1'b1);
    frame_and_check("stop2_bad", 8'h5A, 1'b0, 1'b1, 1'b0);
    do_clr("clr4");

    // Back-to-back frames without clr: overrun
    set_cfg(1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    frame_and_check("overrun", 8'h22, 1'b0, 1'b1, 1'b1);
    do_clr("clr5");

    // Short glitch: false start
    rx = 1'b0;
    wait_clks(10);
    @(negedge clk);
    check("glitch_busy_hi", 32'(recv_busy), 32'd1);
    @(posedge clk); #1;
    wait_clks(9);
    rx = 1'b1;
    wait_clks(2 * bit_clks());
    @(negedge clk);
    check("glitch_busy_lo", 32'(recv_busy), 32'd0);
    @(posedge clk); #1;
    check_flags("glitch");

    // Break: rx held low for many bit times
    rx = 1'b0;
    wait_clks(12 * bit_clks());
    m_data = 8'h00; m_int = 1'b1; m_err = 1'b1;
    @(negedge clk);
    check("break_no_restart", 32'(recv_busy), 32'd0);
    @(posedge clk); #1;
    check_flags("break");
    rx = 1'b1;
    wait_clks(2 * bit_clks());
    do_clr("clr6");
    frame_and_check("post_break", 8'h6E, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset during DATA of 0xFF
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    check("pre_rst_busy", 32'(recv_busy), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    m_data = 8'h00; m_int = 1'b0; m_err = 1'b0;
    check("arst_data", 32'(recv_data), 32'd0);
    check("arst_int", 32'(recv_int), 32'd0);
    check("arst_busy", 32'(recv_busy), 32'd0);
    check("arst_err", 32'(recv_error), 32'd0);
    @(posedge clk); #1;
    rx = 1'b1;
    wait_clks(2);
    arst_n = 1'b1;
    wait_clks(2 * bit_clks());
    check_flags("post_rst_idle");
    frame_and_check("post_rst_81", 8'h81, 1'b0, 1'b1, 1'b1);

    // clr coincident with completion while recv_int already set
    found = 1'b0;
    seen_busy = 1'b0;
    fork
      begin
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        rx = 1'b1;
      end
      begin
        for (int n = 0; n < 2000 && !found; n++) begin
          @(negedge clk);
          if (recv_busy) seen_busy = 1'b1;
          else if (seen_busy) begin
            found = 1'b1;
            clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
            @(negedge clk);
            check("clr_coincide_int", 32'(recv_int), 32'd1);
            check("clr_coincide_err", 32'(recv_error), 32'd0);
          end
        end
      end
    join
    check("clr_coincide_seen", 32'(found), 32'd1);
    m_int = 1'b1; m_err = 1'b0;
    @(posedge clk); #1;
    wait_clks(bit_clks());
    check_flags("clr_coincide");

    // Randomized frames and configurations
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic       flip, s1, s2;
      cfg_baud_div = 16'($urandom_range(0, 3));
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      d    = 8'($urandom);
      flip = cfg_parity_en && ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 4) != 0);
      s2   = ($urandom_range(0, 4) != 0);
      frame_and_check($sformatf("rnd%0d", k), d, flip, s1, s2);
      if ($urandom_range(0, 1) == 1) do_clr($sformatf("rnd_clr%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
